// File: rtl/mac_accumulator_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator_ctrl_if
// Brief    : Bundle of the control, adder-side and result handshake signals of
//            the MAC accumulator stage. The slave modport is the accumulator
//            block; the master modport is its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface mac_accumulator_ctrl_if #(
    parameter int CNT_W = 4
) ();
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       sum;
    logic             carry;
    logic [7:0]       acc_a;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       result;
    logic             overflow;
    logic             busy;

    modport slave (
        input  start, len, in_valid, sum, carry, out_ready,
        output in_ready, acc_a, out_valid, result, overflow, busy
    );

    modport master (
        output start, len, in_valid, sum, carry, out_ready,
        input  in_ready, acc_a, out_valid, result, overflow, busy
    );
endinterface
`default_nettype wire

// File: rtl/mac_accumulator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac_accumulator_ctrl
// Brief    : Accumulator stage behind the 8+4 bit ripple adder. Owns the 8-bit
//            accumulator (adder A operand), counts a programmable number of
//            terms and presents the final sum through a valid/ready handshake.
//            Optional macro MAC_ACC_SATURATE_EN: clamp the accumulator to 8'hFF
//            on a carry instead of wrapping modulo 256.
// Revision : 1.0 - initial release
// ============================================================================
module mac_accumulator_ctrl #(
    parameter int CNT_W = 4
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    mac_accumulator_ctrl_if.slave   bus
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    // len==0 encodes the maximum run length 2^CNT_W, hence one extra bit
    localparam logic [CNT_W:0] c_FULL_LEN = {1'b1, {CNT_W{1'b0}}};
    localparam logic [CNT_W:0] c_ONE      = {{CNT_W{1'b0}}, 1'b1};

    logic [1:0]     r_state;
    logic [1:0]     w_state_next;
    logic [CNT_W:0] r_cnt;
    logic [7:0]     r_acc;
    logic           r_ovf;
    logic           w_start_run;
    logic           w_accept;
    logic           w_last;
    logic [7:0]     w_acc_next;
    logic [CNT_W:0] w_cnt_load;

    assign w_start_run = (r_state == c_IDLE) && bus.start;
    assign w_accept    = (r_state == c_ACCUM) && bus.in_valid;
    assign w_last      = (r_cnt == c_ONE);
    assign w_cnt_load  = (bus.len == '0) ? c_FULL_LEN : {1'b0, bus.len};

`ifdef MAC_ACC_SATURATE_EN
    // A carry means the true sum exceeded 255; pin the accumulator at full scale
    assign w_acc_next = bus.carry ? 8'hFF : bus.sum;
`else
    assign w_acc_next = bus.sum;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only looked at in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (bus.start)             w_state_next = c_ACCUM;
            c_ACCUM: if (w_accept && w_last)    w_state_next = c_DONE;
            c_DONE:  if (bus.out_ready)         w_state_next = c_IDLE;
            default:                            w_state_next = c_IDLE;
        endcase
    end

    // Handshake outputs decoded from the registered state only
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            c_ACCUM: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
            end
            c_DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulator, sticky overflow and term counter; values hold in IDLE so the
    // last result stays readable until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 8'd0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else if (w_start_run) begin
            r_acc <= 8'd0;
            r_ovf <= 1'b0;
            r_cnt <= w_cnt_load;
        end else if (w_accept) begin
            r_acc <= w_acc_next;
            r_ovf <= r_ovf | bus.carry;
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign bus.acc_a    = r_acc;
    assign bus.result   = r_acc;
    assign bus.overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_accumulator_ctrl
// Brief    : Directed self-checking bench for mac_accumulator_ctrl. Models the
//            8+4 bit adder in front of the block, with an override to inject a
//            chosen sum so that a wrap can be reached within a 16-term limit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_accumulator_ctrl;

    localparam int CNT_W = 4;

    logic clk;
    logic rst_n;
    logic [3:0] prod;
    logic       force_en;
    logic [7:0] force_sum;
    int total;
    int bad;
    int accepts;

    mac_accumulator_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mac_accumulator_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Adder in front of the accumulator: acc_a + 4-bit product
    assign {bus.carry, bus.sum} = force_en ? {1'b0, force_sum}
                                           : ({1'b0, bus.acc_a} + {5'b0, prod});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted terms
    always @(posedge clk) begin
        if (rst_n && bus.in_ready && bus.in_valid) accepts++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic [7:0] wrap_exp;

    initial begin
        total = 0; bad = 0; accepts = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        prod = 4'd0; force_en = 1'b0; force_sum = 8'd0;
`ifdef MAC_ACC_SATURATE_EN
        wrap_exp = 8'd255;
`else
        wrap_exp = 8'd4;
`endif
        step(); step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_acc_a", bus.acc_a, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_busy", bus.busy, 0);

        // Basic run: 3+5+7+9, start at cycle 0
        bus.start = 1'b1; bus.len = 4'd4; bus.in_valid = 1'b1; prod = 4'd3;
        step();
        bus.start = 1'b0;
        chk("basic_in_ready_c1", bus.in_ready, 1);
        chk("basic_busy_c1", bus.busy, 1);
        chk("basic_acc_cleared", bus.acc_a, 0);
        step(); prod = 4'd5;
        chk("basic_acc_after1", bus.acc_a, 3);
        step(); prod = 4'd7;
        step(); prod = 4'd9;
        chk("basic_no_valid_early", bus.out_valid, 0);
        step();
        bus.in_valid = 1'b0;
        chk("basic_out_valid_c5", bus.out_valid, 1);
        chk("basic_result", bus.result, 24);
        chk("basic_overflow", bus.overflow, 0);
        chk("basic_in_ready_done", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("basic_done_cleared", bus.out_valid, 0);
        chk("basic_idle_busy", bus.busy, 0);
        chk("basic_result_held", bus.result, 24);

        // Stalls and backpressure: 10, 3 idle cycles, 6
        bus.start = 1'b1; bus.len = 4'd2;
        step();
        bus.start = 1'b0; bus.in_valid = 1'b1; prod = 4'd10;
        step();
        bus.in_valid = 1'b0; prod = 4'd1;
        step(); step(); step();
        chk("stall_in_ready", bus.in_ready, 1);
        chk("stall_acc_stable", bus.acc_a, 10);
        bus.in_valid = 1'b1; prod = 4'd6;
        step();
        bus.in_valid = 1'b0;
        chk("stall_out_valid", bus.out_valid, 1);
        chk("stall_result", bus.result, 16);
        bus.start = 1'b1; bus.len = 4'd5;
        for (int i = 0; i < 4; i++) step();
        chk("bp_out_valid", bus.out_valid, 1);
        chk("bp_result", bus.result, 16);
        chk("bp_in_ready", bus.in_ready, 0);
        bus.start = 1'b0; bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp_back_idle", bus.busy, 0);

        // Full length with 18 offered terms: only 16 accepted
        bus.start = 1'b1; bus.len = 4'd0;
        step();
        bus.start = 1'b0; bus.in_valid = 1'b1; prod = 4'd15;
        accepts = 0;
        for (int i = 0; i < 18; i++) step();
        bus.in_valid = 1'b0;
        chk("full_accepts", accepts, 16);
        chk("full_out_valid", bus.out_valid, 1);
        chk("full_result", bus.result, 240);
        chk("full_overflow", bus.overflow, 0);
        bus.out_ready = 1'b1;
        step();

        // len=2 from 0: 15+15
        bus.out_ready = 1'b0; bus.start = 1'b1; bus.len = 4'd2;
        step();
        bus.start = 1'b0; bus.in_valid = 1'b1; prod = 4'd15;
        step(); step();
        bus.in_valid = 1'b0;
        chk("len2_result", bus.result, 30);
        chk("len2_out_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        step();

        // Wrap: inject sum 250, then add 10 through the adder model
        bus.out_ready = 1'b0; bus.start = 1'b1; bus.len = 4'd2;
        step();
        bus.start = 1'b0; bus.in_valid = 1'b1; force_en = 1'b1; force_sum = 8'd250;
        step();
        force_en = 1'b0; prod = 4'd10;
        chk("wrap_preload", bus.acc_a, 250);
        chk("wrap_no_ovf_yet", bus.overflow, 0);
        step();
        bus.in_valid = 1'b0;
        chk("wrap_result", bus.result, wrap_exp);
        chk("wrap_overflow", bus.overflow, 1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("wrap_ovf_held_idle", bus.overflow, 1);
        chk("wrap_result_held_idle", bus.result, wrap_exp);

        // Back-to-back: start on the first IDLE cycle after DONE
        bus.start = 1'b1; bus.len = 4'd1;
        step();
        bus.start = 1'b0;
        chk("b2b_acc_cleared", bus.acc_a, 0);
        chk("b2b_ovf_cleared", bus.overflow, 0);
        bus.in_valid = 1'b1; prod = 4'd7;
        step();
        bus.in_valid = 1'b0;
        chk("b2b_out_valid", bus.out_valid, 1);
        chk("b2b_result", bus.result, 7);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Reset mid-run
        bus.start = 1'b1; bus.len = 4'd3;
        step();
        bus.start = 1'b0; bus.in_valid = 1'b1; prod = 4'd5;
        step();
        bus.in_valid = 1'b0;
        chk("mid_acc_before_rst", bus.acc_a, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_acc", bus.acc_a, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        step();
        rst_n = 1'b1;
        step();
        bus.start = 1'b1; bus.len = 4'd1;
        step();
        bus.start = 1'b0; bus.in_valid = 1'b1; prod = 4'd4;
        step();
        bus.in_valid = 1'b0;
        chk("post_rst_result", bus.result, 4);
        chk("post_rst_out_valid", bus.out_valid, 1);
        chk("post_rst_overflow", bus.overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
